// File: rtl/stream_pkg.sv
// stream_pkg: shared arbiter state encoding and source identifiers
package stream_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOCK_A, ST_LOCK_B} arb_state_t;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker, ties go opposite last_src
module rr_arb2
  import stream_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_src,
  output logic       grant,
  output logic       grant_valid
);
  assign grant_valid = |req;
  assign grant = &req ? ~last_src : (req[1] ? SRC_B : SRC_A);
endmodule

// File: rtl/stream_arb2to1.sv
// stream_arb2to1: 2:1 valid/ready arbiter with packet lock and registered output
module stream_arb2to1
  import stream_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter bit LOCK_ON_LAST = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic              y_last,
  output logic              sel
);
  arb_state_t        state;
  logic              last_src, arb_grant, arb_valid, gnt, gnt_ok, load, acc, in_last;
  logic [DATA_W-1:0] in_data;
  rr_arb2 u_rr (
    .req        ({b_valid, a_valid}),
    .last_src   (last_src),
    .grant      (arb_grant),
    .grant_valid(arb_valid)
  );
  // A locked state owns the output regardless of the other source's valid
  always_comb begin
    gnt     = state == ST_LOCK_A ? SRC_A : state == ST_LOCK_B ? SRC_B : arb_grant;
    gnt_ok  = state != ST_IDLE || arb_valid;
    load    = !y_valid || y_ready;
    a_ready = reset_n && load && gnt_ok && gnt == SRC_A;
    b_ready = reset_n && load && gnt_ok && gnt == SRC_B;
    acc     = (a_valid && a_ready) || (b_valid && b_ready);
    in_data = gnt == SRC_B ? b_data : a_data;
    in_last = gnt == SRC_B ? b_last : a_last;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      last_src <= SRC_B;
      y_valid  <= 1'b0;
      y_data   <= '0;
      y_last   <= 1'b0;
      sel      <= SRC_A;
    end else if (acc) begin
      y_valid  <= 1'b1;
      y_data   <= in_data;
      y_last   <= in_last;
      sel      <= gnt;
      last_src <= gnt;
      state    <= (!LOCK_ON_LAST || in_last) ? ST_IDLE : (gnt == SRC_B ? ST_LOCK_B : ST_LOCK_A);
    end else if (y_ready) begin
      y_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_arb2to1.sv
// tb_stream_arb2to1: directed checks of lock, fairness, backpressure and reset
module tb_stream_arb2to1;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0, y_ready = 1'b1;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, y_valid, y_last, sel;
  logic [7:0] y_data;
  logic       n_a_ready, n_b_ready, n_y_valid, n_y_last, n_sel;
  logic [7:0] n_y_data;
  logic       use_nl = 1'b0;
  logic [8:0] qa[$], qb[$], obs[$];
  int         n_tests = 0, n_fail = 0;
  logic [7:0] lock_d[4] = '{8'h11, 8'h12, 8'h13, 8'h21};
  logic       lock_s[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic       lock_br[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [8:0] bp_exp[4] = '{9'h031, 9'h032, 9'h033, 9'h134};

  always #5 clk = ~clk;

  stream_arb2to1 dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_last(y_last), .sel(sel)
  );

  stream_arb2to1 #(.DATA_W(8), .LOCK_ON_LAST(0)) dut_nl (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(n_a_ready), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(n_b_ready), .b_data(b_data), .b_last(b_last),
    .y_valid(n_y_valid), .y_ready(y_ready), .y_data(n_y_data), .y_last(n_y_last), .sel(n_sel)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    a_valid = qa.size() != 0;
    b_valid = qb.size() != 0;
    {a_last, a_data} = a_valid ? qa[0] : 9'h0;
    {b_last, b_data} = b_valid ? qb[0] : 9'h0;
  endtask

  // Handshakes are sampled mid-cycle; sources advance just after the edge
  task automatic tick();
    logic ha, hb;
    @(negedge clk);
    ha = a_valid && (use_nl ? n_a_ready : a_ready);
    hb = b_valid && (use_nl ? n_b_ready : b_ready);
    if (!use_nl && y_valid && y_ready) obs.push_back({y_last, y_data});
    @(posedge clk);
    #1;
    if (ha) void'(qa.pop_front());
    if (hb) void'(qb.pop_front());
    drive();
  endtask

  initial begin
    qa = '{9'h011, 9'h012, 9'h113};
    qb = '{9'h121};
    drive();
    repeat (3) tick();
    check("rst_y_valid", y_valid, 0);
    check("rst_sel", sel, 0);
    check("rst_y_data", y_data, 0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    reset_n = 1'b1;
    #1;
    check("rel_a_ready", a_ready, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lock_b_ready%0d", k), b_ready, lock_br[k]);
      tick();
      check($sformatf("lock_y_valid%0d", k), y_valid, 1);
      check($sformatf("lock_y_data%0d", k), y_data, lock_d[k]);
      check($sformatf("lock_sel%0d", k), sel, lock_s[k]);
    end
    check("lock_y_last", y_last, 1);
    tick();
    check("drain_y_valid", y_valid, 0);

    qa = '{9'h1A1, 9'h1A2, 9'h1A3};
    qb = '{9'h1B1, 9'h1B2, 9'h1B3};
    drive();
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr_y_data%0d", k), y_data, (k % 2 ? 8'hB1 : 8'hA1) + 8'(k / 2));
      check($sformatf("rr_sel%0d", k), sel, k % 2);
    end
    tick();
    check("rr_drain", y_valid, 0);

    obs.delete();
    qa = '{9'h031, 9'h032, 9'h033, 9'h134};
    drive();
    repeat (2) tick();
    y_ready = 1'b0;
    #1;
    check("bp_a_ready", a_ready, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("bp_hold_data%0d", k), y_data, 8'h32);
      check($sformatf("bp_hold_ready%0d", k), a_ready, 0);
    end
    y_ready = 1'b1;
    repeat (4) tick();
    check("bp_count", obs.size(), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("bp_beat%0d", k), k < obs.size() ? obs[k] : 9'h1FF, bp_exp[k]);

    qa = '{9'h041, 9'h042, 9'h043};
    drive();
    repeat (2) tick();
    qb = '{9'h151};
    drive();
    #1;
    check("mid_b_locked", b_ready, 0);
    reset_n = 1'b0;
    tick();
    check("mid_rst_y_valid", y_valid, 0);
    reset_n = 1'b1;
    qa = '{9'h061, 9'h162};
    drive();
    #1;
    check("mid_a_wins", a_ready, 1);
    check("mid_b_wait", b_ready, 0);
    tick();
    check("mid_d0", y_data, 8'h61);
    tick();
    check("mid_d1", y_data, 8'h62);
    check("mid_b_free", b_ready, 1);
    tick();
    check("mid_b_data", y_data, 8'h51);
    check("mid_b_sel", sel, 1);
    tick();

    use_nl = 1'b1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    qa = '{9'h071, 9'h072, 9'h173};
    qb = '{9'h081, 9'h082, 9'h183};
    drive();
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("nl_y_data%0d", k), n_y_data, (k % 2 ? 8'h81 : 8'h71) + 8'(k / 2));
      check($sformatf("nl_sel%0d", k), n_sel, k % 2);
    end
    tick();
    check("nl_drain", n_y_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
